// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
package modexp_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ONE            = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO with a first-word-fall-through head; reads as 0 when empty.
module result_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              rd_fire;
    logic              wr_fire;
    logic              empty;
    logic              full;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(FIFO_DEPTH));

    // A write into a full FIFO is allowed when the head leaves in the same cycle.
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/modexp_sequencer.sv
// Streams message words through a single-shot modexp engine and buffers results in order.
// Optional MODEXP_SHORTCUT_EN resolves trivial cases (mod 1, exp 0, base 0) without the engine.
module modexp_sequencer
    import modexp_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              key_load,
    input  logic [DATA_W-1:0] key_exp,
    input  logic [DATA_W-1:0] key_mod,
    output logic              key_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              eng_md_start,
    output logic [DATA_W-1:0] eng_base,
    output logic [DATA_W-1:0] eng_exp,
    output logic [DATA_W-1:0] eng_modulus,
    input  logic [DATA_W-1:0] eng_r,
    input  logic              eng_md_end
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_reg;
    logic [DATA_W-1:0] key_exp_reg;
    logic [DATA_W-1:0] key_mod_reg;
    logic              key_valid_reg;
    logic              key_err_reg;
    logic              eng_md_start_reg;
    logic [DATA_W-1:0] eng_base_reg;
    logic [DATA_W-1:0] eng_exp_reg;
    logic [DATA_W-1:0] eng_mod_reg;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_rd_en;
    logic              accept;
    logic              eng_done;
    logic              trivial;
    logic [DATA_W-1:0] trivial_val;

    assign in_ready = (state_reg == IDLE) && key_valid_reg
                      && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;

`ifdef MODEXP_SHORTCUT_EN
    always_comb begin
        trivial     = 1'b0;
        trivial_val = '0;
        if (key_mod_reg == DATA_W'(ONE)) begin
            trivial = 1'b1;
        end else if (key_exp_reg == '0) begin
            trivial     = 1'b1;
            trivial_val = DATA_W'(ONE);
        end else if (in_data == '0) begin
            trivial = 1'b1;
        end
    end
`else
    assign trivial     = 1'b0;
    assign trivial_val = '0;
`endif

    // Completions outside WAIT are spurious and never reach the FIFO.
    assign eng_done     = (state_reg == WAIT) && eng_md_end;
    assign fifo_wr_en   = eng_done || (accept && trivial);
    assign fifo_wr_data = eng_done ? eng_r : trivial_val;
    assign fifo_rd_en   = out_ready && out_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= IDLE;
            key_exp_reg      <= '0;
            key_mod_reg      <= '0;
            key_valid_reg    <= 1'b0;
            key_err_reg      <= 1'b0;
            eng_md_start_reg <= 1'b0;
            eng_base_reg     <= '0;
            eng_exp_reg      <= '0;
            eng_mod_reg      <= '0;
        end else begin
            key_err_reg      <= 1'b0;
            eng_md_start_reg <= 1'b0;

            // The key can only change between words so in-flight operands stay coherent.
            if (key_load) begin
                if (state_reg == IDLE) begin
                    key_exp_reg   <= key_exp;
                    key_mod_reg   <= key_mod;
                    key_valid_reg <= 1'b1;
                end else begin
                    key_err_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (accept && !trivial) begin
                        eng_base_reg     <= in_data;
                        eng_exp_reg      <= key_exp_reg;
                        eng_mod_reg      <= key_mod_reg;
                        eng_md_start_reg <= 1'b1;
                        state_reg        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (eng_md_end) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    result_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (fifo_wr_en),
        .wr_data (fifo_wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (out_data),
        .count   (fifo_count)
    );

    assign out_valid    = (fifo_count != '0);
    assign busy         = (state_reg != IDLE);
    assign key_err      = key_err_reg;
    assign eng_md_start = eng_md_start_reg;
    assign eng_base     = eng_base_reg;
    assign eng_exp      = eng_exp_reg;
    assign eng_modulus  = eng_mod_reg;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer: behavioural 10-cycle engine, result scoreboard, vector table.
module tb_modexp_sequencer;

    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int ENG_LAT = 10;

    logic          clk;
    logic          rstn;
    logic          key_load;
    logic [DW-1:0] key_exp;
    logic [DW-1:0] key_mod;
    logic          key_err;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          eng_md_start;
    logic [DW-1:0] eng_base;
    logic [DW-1:0] eng_exp;
    logic [DW-1:0] eng_modulus;
    logic [DW-1:0] eng_r;
    logic          eng_md_end;

    int checks;
    int errors;
    int start_count;
    int inject_cnt;
    logic [DW-1:0] sb_q[$];

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] expv;
    } vec_t;
    vec_t vecs[5];

    modexp_sequencer #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .key_load     (key_load),
        .key_exp      (key_exp),
        .key_mod      (key_mod),
        .key_err      (key_err),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .eng_md_start (eng_md_start),
        .eng_base     (eng_base),
        .eng_exp      (eng_exp),
        .eng_modulus  (eng_modulus),
        .eng_r        (eng_r),
        .eng_md_end   (eng_md_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mexp(input logic [DW-1:0] b, input logic [DW-1:0] e,
                                           input logic [DW-1:0] m);
        longint unsigned r;
        longint unsigned bb;
        longint unsigned mm;
        if (m == '0) return '0;
        mm = longint'(m);
        r  = 64'd1 % mm;
        bb = longint'(b) % mm;
        for (int i = 0; i < DW; i++) begin
            if (e[i]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return r[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Engine model: latch operands on start, answer ENG_LAT cycles later, drop work on reset.
    initial begin
        int busy_cnt;
        int inject_seen;
        logic [DW-1:0] cap_b, cap_e, cap_m;
        busy_cnt = 0;
        inject_seen = 0;
        eng_md_end = 1'b0;
        eng_r = '0;
        forever begin
            @(negedge clk);
            eng_md_end = 1'b0;
            if (!rstn) begin
                busy_cnt = 0;
            end else begin
                if (inject_cnt != inject_seen) begin
                    inject_seen++;
                    eng_md_end = 1'b1;
                    eng_r = 32'hDEAD_BEEF;
                end
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        chk("eng_base_stable", eng_base, cap_b);
                        chk("eng_exp_stable", eng_exp, cap_e);
                        chk("eng_mod_stable", eng_modulus, cap_m);
                        eng_md_end = 1'b1;
                        eng_r = mexp(cap_b, cap_e, cap_m);
                    end
                end
                if (eng_md_start) begin
                    start_count++;
                    cap_b = eng_base;
                    cap_e = eng_exp;
                    cap_m = eng_modulus;
                    busy_cnt = ENG_LAT;
                end
            end
        end
    end

    // Output monitor: every consumed result must match the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%0d required=none", out_data);
                end else begin
                    chk("out_data", out_data, sb_q.pop_front());
                end
            end
        end
    end

    task automatic load_key(input logic [DW-1:0] e, input logic [DW-1:0] m);
        @(posedge clk); #1;
        key_load = 1'b1;
        key_exp  = e;
        key_mod  = m;
        @(posedge clk); #1;
        key_load = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] expv);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                sb_q.push_back(expv);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_not_busy();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int s0;
        logic [DW-1:0] bp_words[5];

        vecs[0] = '{data: 32'd4,   expv: 32'd445};
        vecs[1] = '{data: 32'd2,   expv: 32'd240};
        vecs[2] = '{data: 32'd3,   expv: 32'd444};
        vecs[3] = '{data: 32'd496, expv: 32'd496};
        vecs[4] = '{data: 32'd1,   expv: 32'd1};
        bp_words[0] = 32'd5;
        bp_words[1] = 32'd6;
        bp_words[2] = 32'd7;
        bp_words[3] = 32'd8;
        bp_words[4] = 32'd12;

        checks = 0;
        errors = 0;
        start_count = 0;
        inject_cnt = 0;
        rstn = 1'b0;
        key_load = 1'b0;
        key_exp = '0;
        key_mod = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_md_start", {31'd0, eng_md_start}, 32'd0);
        chk("rst_key_err", {31'd0, key_err}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_eng_base", eng_base, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("no_key_in_ready", {31'd0, in_ready}, 32'd0);

        load_key(32'd13, 32'd497);
        @(negedge clk);
        chk("key_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            s0 = start_count;
            send(vecs[i].data, vecs[i].expv);
            wait_drain();
            chk("starts_per_word", 32'(start_count - s0), 32'd1);
        end

        // Back-to-back pair: ordering through the FIFO.
        send(32'd4, 32'd445);
        send(32'd2, 32'd240);
        wait_drain();

        // Backpressure: four results fill the FIFO and block input.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(bp_words[i], mexp(bp_words[i], 32'd13, 32'd497));
            wait_not_busy();
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, (i < DEPTH - 1) ? 32'd1 : 32'd0);
        end
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        fork
            send(bp_words[4], mexp(bp_words[4], 32'd13, 32'd497));
            begin
                repeat (6) @(negedge clk);
                chk("bp_held_off", {31'd0, in_ready}, 32'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // key_load while the engine is working is rejected and leaves operands intact.
        send(32'd9, mexp(32'd9, 32'd13, 32'd497));
        @(posedge clk); #1;
        key_load = 1'b1;
        key_exp  = 32'd3;
        key_mod  = 32'd11;
        @(posedge clk); #1;
        key_load = 1'b0;
        @(negedge clk);
        chk("key_err_pulse", {31'd0, key_err}, 32'd1);
        chk("wait_eng_exp", eng_exp, 32'd13);
        chk("wait_eng_mod", eng_modulus, 32'd497);
        chk("wait_eng_base", eng_base, 32'd9);
        @(negedge clk);
        chk("key_err_clear", {31'd0, key_err}, 32'd0);
        wait_drain();
        send(32'd10, mexp(32'd10, 32'd13, 32'd497));
        wait_drain();

        // Spurious completion while idle.
        inject_cnt++;
        repeat (3) @(negedge clk);
        chk("spur_out_valid", {31'd0, out_valid}, 32'd0);
        chk("spur_busy", {31'd0, busy}, 32'd0);
        chk("spur_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in WAIT, then a late completion.
        send(32'd11, mexp(32'd11, 32'd13, 32'd497));
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        inject_cnt++;
        repeat (3) @(negedge clk);
        chk("rstwait_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstwait_busy", {31'd0, busy}, 32'd0);
        chk("rstwait_out_data", out_data, 32'd0);
        chk("rstwait_in_ready", {31'd0, in_ready}, 32'd0);

        // Trivial operands: exp 0 gives 1, modulus 1 gives 0.
        load_key(32'd0, 32'd13);
        s0 = start_count;
        send(32'd7, 32'd1);
`ifdef MODEXP_SHORTCUT_EN
        @(negedge clk);
        chk("short_out_valid", {31'd0, out_valid}, 32'd1);
        wait_drain();
        chk("short_no_start", 32'(start_count - s0), 32'd0);
`else
        wait_drain();
        chk("exp0_starts", 32'(start_count - s0), 32'd1);
`endif
        load_key(32'd5, 32'd1);
        send(32'd5, 32'd0);
        wait_drain();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/modexp_sequencer.md
Name: modexp_sequencer

Overview:
- Initiator side of the modular-exponentiation md_start/md_end handshake. It accepts a stream of message words, issues one exponentiation per word to an external modexp engine (base = word, exp/modulus = loaded key), and buffers results in an output FIFO with valid/ready.
- Sits between the host/stream interface and the RL_binary-style engine, and turns the single-shot engine into an RSA block encrypt/decrypt stream.

Parameters:
- DATA_W, 32, width of words, exponent and modulus.
- FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- key_load  in  1  one-cycle pulse; latch key_exp and key_mod.
- key_exp  in  DATA_W  exponent.
- key_mod  in  DATA_W  modulus; must be nonzero.
- key_err  out  1  one-cycle pulse when key_load is rejected.
- in_valid  in  1  message word valid.
- in_ready  out  1  sequencer accepts the word.
- in_data  in  DATA_W  message word.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  DATA_W  result word.
- busy  out  1  state is not IDLE.
- eng_md_start  out  1  one-cycle start pulse to the engine.
- eng_base  out  DATA_W  base to the engine.
- eng_exp  out  DATA_W  exponent to the engine.
- eng_modulus  out  DATA_W  modulus to the engine.
- eng_r  in  DATA_W  engine result, valid with eng_md_end.
- eng_md_end  in  1  one-cycle done pulse from the engine.

Behaviour:
- Reset values: all outputs 0; FIFO empty; key_valid=0; state IDLE. Reset asserted mid-operation aborts immediately; an eng_md_end arriving after reset is ignored, because the state is IDLE.
- Key register: key_load is accepted only in IDLE. It latches key_exp and key_mod and sets key_valid. If key_load arrives in any other state it is ignored, the key is unchanged, and key_err pulses for 1 cycle.
- in_ready = (state==IDLE) && key_valid && (fifo_count < FIFO_DEPTH). in_ready is combinational from registered state only.
- States:
  - IDLE: on in_valid&&in_ready, latch in_data into eng_base, go to ISSUE.
  - ISSUE: drive eng_md_start=1 for exactly one cycle, go to WAIT.
  - WAIT: wait for eng_md_end. On eng_md_end, write eng_r into the FIFO in that same cycle and go to IDLE.
- FIFO space is guaranteed at issue time, so the write in WAIT never overflows.
- eng_base, eng_exp and eng_modulus are registered and held stable from ISSUE until the cycle eng_md_end is seen.
- Latency: input handshake at cycle N → eng_md_start at N+1 → engine done at cycle M → out_valid at M+1 (FIFO was empty).
- Throughput: one word in flight at a time.
- An eng_md_end pulse in IDLE or ISSUE is spurious and is ignored.
- FIFO:
  - Write and read in the same cycle while full is legal; the count is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - out_data shows the head entry; it is 0 when the FIFO is empty.
- Results leave in the same order the words entered.

Optional Feature:
- Macro MODEXP_SHORTCUT_EN.
- When defined, IDLE checks each accepted word against the trivial cases:
  - if key_mod==1, the result is 0;
  - else if key_exp==0, the result is 1;
  - else if in_data==0, the result is 0.
- A trivial case pushes its result straight into the FIFO on the acceptance cycle and stays in IDLE. No engine pulse is issued, so out_valid rises the next cycle.
- When not defined, every word goes through the engine.

Decomposition:
- Shared package modexp_pkg holds:
  - state encoding localparams IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2;
  - the default DATA_W;
  - the constant ONE = 1.
- Sub-module result_fifo is natural: a synchronous FIFO with parameters DATA_W and FIFO_DEPTH, ports wr_en/wr_data/rd_en/rd_data/count, and asynchronous active-low reset.
- The FSM and key register stay in the top level.

Test Plan:
- Key load, then stream: key_exp=13, key_mod=497; send in_data 4, then 2, with a behavioural engine model of 10-cycle latency.
  - Required: out_data 445, then 8192 mod 497 = 240, in order.
  - Required: exactly one eng_md_start per word.
- Backpressure: out_ready=0; send FIFO_DEPTH+1 words.
  - Required: in_ready drops after 4 results are buffered.
  - Required: after out_ready=1, the fifth word is accepted and all 5 results come out in order.
- key_load during WAIT: key_err pulses; the engine operands keep the old values; the next word uses the old key.
- Reset mid-WAIT: assert rstn=0, then release, then inject a late eng_md_end.
  - Required: FIFO stays empty, out_valid=0, busy=0.
- Spurious eng_md_end in IDLE: no FIFO write, no state change.
- With MODEXP_SHORTCUT_EN: key_exp=0, key_mod=13, in_data=7.
  - Required: result 1, no eng_md_start pulse, out_valid one cycle after acceptance.
  - Required: with key_mod=1, the result is 0.
